// File: rtl/uart_32_bit_pkg.sv
// Shared types and frame constants for the 32-bit UART transmit path.
// UART_TX_PARITY_EN adds an even-parity bit and the PARITY state (11-bit frames).
package uart_32_bit_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

endpackage

// File: rtl/uart_32_bit_tx_fifo.sv
// Word FIFO with same-cycle push+pop; count/full are registered, a push while full is dropped.
// Dropped pushes raise overflow for one cycle, one cycle after the offending push.
module uart_32_bit_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered count, so a simultaneous pop cannot rescue a push.
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_32_bit_tx_framer.sv
// Serializes queued 32-bit words as four LSB-first 8N1 byte frames; push-to-start-bit is 2 cycles.
// No backpressure: pushes into a full FIFO are dropped and flagged; UART_TX_PARITY_EN adds even parity.
module uart_32_bit_tx_framer
  import uart_32_bit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t               state;
  state_t               state_d;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] baud_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_d;
  logic [1:0]           byte_idx;
  logic [1:0]           byte_d;
  logic [31:0]          word;
  logic [31:0]          word_d;
  logic [31:0]          fifo_head;
  logic                 fifo_empty;
  logic                 pop;
  logic                 tick;
  logic                 tx_d;

  uart_32_bit_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign fifo_empty = (fifo_count == '0);
  assign tick       = (baud_cnt == div_q);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      div_q    <= div_d;
      bit_idx  <= bit_d;
      byte_idx <= byte_d;
      word     <= word_d;
      tx       <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = tick ? '0 : baud_cnt + DIV_WIDTH'(1);
    div_d   = div_q;
    bit_d   = bit_idx;
    byte_d  = byte_idx;
    word_d  = word;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = fifo_head;
          div_d   = clk_div;
          byte_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (byte_idx != LAST_BYTE) begin
            byte_d  = byte_idx + 2'd1;
            state_d = ST_START;
          end else if (!fifo_empty) begin
            // Chain straight into the next word so its start bit abuts this stop bit.
            pop     = 1'b1;
            word_d  = fifo_head;
            div_d   = clk_div;
            byte_d  = '0;
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx is registered from the next-state view so the start bit appears on the pop edge.
  always_comb begin
    busy = (state != ST_IDLE);
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = word_d[{byte_d, bit_d}];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^word_d[{byte_d, 3'b000} +: DATA_BITS];
`endif
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_32_bit_tx_framer.sv
// Directed bench for uart_32_bit_tx_framer: reset, single word, back-to-back, overflow, mid-frame reset,
// and the parity frame when UART_TX_PARITY_EN is defined.
module tb_uart_32_bit_tx_framer;
  import uart_32_bit_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] clk_div = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        busy;
  logic        tx;

  int n_assert = 0;
  int n_fail   = 0;
  bit txs[$];

  always #5 aclk = ~aclk;

  uart_32_bit_tx_framer #(
    .FIFO_DEPTH (4),
    .DIV_WIDTH  (16)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .clk_div    (clk_div),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line-order frame: bit 0 start, bits 1..8 data LSB first, then optional parity, then stop.
  function automatic logic [31:0] frame_of(input logic [7:0] b);
    logic [31:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Push one or two words on consecutive cycles from idle and check the serial stream.
  task automatic run_words(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input int nwords, input int div);
    int          p;
    int          w_cycles;
    logic        busy_all;
    logic [31:0] obs;
    logic [31:0] w;
    p        = div + 1;
    w_cycles = nwords * BYTES_PER_WORD * FRAME_BITS * p;
    clk_div  = 16'(div);
    wr_en    = 1'b1;
    wr_data  = w0;
    @(negedge aclk);
    if (nwords == 2) wr_data = w1;
    else wr_en = 1'b0;
    check($sformatf("%s_count_n1", tag), fifo_count, 1);
    check($sformatf("%s_tx_n1", tag), tx, 1);
    @(negedge aclk);
    wr_en = 1'b0;
    check($sformatf("%s_start_n2", tag), tx, 0);
    check($sformatf("%s_count_n2", tag), fifo_count, nwords - 1);
    txs.delete();
    busy_all = 1'b1;
    for (int i = 0; i < w_cycles; i++) begin
      txs.push_back(tx);
      busy_all &= busy;
      @(negedge aclk);
    end
    check($sformatf("%s_busy_held", tag), busy_all, 1);
    check($sformatf("%s_busy_fall", tag), busy, 0);
    check($sformatf("%s_tx_idle", tag), tx, 1);
    for (int k = 0; k < nwords * BYTES_PER_WORD; k++) begin
      w   = (k < BYTES_PER_WORD) ? w0 : w1;
      obs = '1;
      for (int j = 0; j < FRAME_BITS; j++) begin
        obs[j] = txs[(k * FRAME_BITS + j) * p + p / 2];
      end
      check($sformatf("%s_frame%0d", tag, k), obs, frame_of(w[(k % 4) * 8 +: 8]));
    end
  endtask

  initial begin
    logic tx_min;
    logic busy_seen;

    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    run_words("single", 32'hA5C3_0F81, 32'h0, 1, 3);
    run_words("b2b", 32'h0000_0000, 32'hFFFF_FFFF, 2, 0);
`ifdef UART_TX_PARITY_EN
    run_words("parity", 32'h0000_0007, 32'h0, 1, 1);
`endif

    // First word is popped immediately, the next four fill the FIFO, the sixth is dropped.
    clk_div = 16'd15;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h1000_0000 + 32'(i);
      @(negedge aclk);
    end
    check("ovf_before", overflow, 0);
    check("ovf_full_before", fifo_full, 1);
    wr_data = 32'h1000_0005;
    @(negedge aclk);
    wr_en = 1'b0;
    check("ovf_pulse", overflow, 1);
    check("ovf_full", fifo_full, 1);
    check("ovf_count", fifo_count, 4);
    @(negedge aclk);
    check("ovf_one_cycle", overflow, 0);

    // Byte 2 of the first word spans roughly cycles 320..479 after its start bit.
    repeat (340) @(negedge aclk);
    check("midrst_busy_before", busy, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_full", fifo_full, 0);
    aresetn   = 1'b1;
    tx_min    = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      tx_min    &= tx;
      busy_seen |= busy;
    end
    check("midrst_no_start", tx_min, 1);
    check("midrst_stay_idle", busy_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_32_bit_tx_framer.md
# uart_32_bit_tx_framer

- **Function:** transmit side of the 32-bit UART datapath. Accepts 32-bit words from the register-write path, buffers them in a small FIFO and serializes each word as four back-to-back byte frames on `tx`.
- **Byte order and line format:** byte 0 (bits 7:0) goes first, each byte LSB first, 8N1 by default.
- **Position:** sits directly downstream of the AXI4-Lite slave register decode and drives the UART pin.

## Interface
**Parameters**
- `FIFO_DEPTH`, default 4: word FIFO depth; power of two, ≥2.
- `DIV_WIDTH`, default 16: width of the baud divider.

**Ports**
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `clk_div` in `DIV_WIDTH`: cycles per bit minus 1, so bit period = `clk_div`+1 cycles.
- `wr_en` in 1: push `wr_data` into the FIFO.
- `wr_data` in 32: word to transmit.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words.
- `fifo_count` out `$clog2(FIFO_DEPTH)`+1: words currently queued, excluding the word in flight.
- `overflow` out 1: one-cycle pulse when a push is dropped.
- `busy` out 1: high whenever state ≠ IDLE.
- `tx` out 1: serial output, registered, idle high.

## Operation
- **FIFO push:** `wr_en`=1 with `fifo_full`=0 stores `wr_data`.
  - `wr_en`=1 with `fifo_full`=1 drops the word and pulses `overflow` for one cycle.
  - `fifo_full` is evaluated on the registered count, so a push while full is dropped even if a pop occurs in the same cycle.
- **States:** IDLE, START, DATA, PARITY (macro only), STOP.
- **IDLE:**
  - If `fifo_count`≠0, pop the head word into the shift register.
  - Latch `clk_div`, clear the byte index and go to START.
  - A push and pop in the same cycle on a non-full FIFO leaves `fifo_count` unchanged.
- **START:** `tx`=0 for one bit period, then DATA.
- **DATA:** 8 bits, LSB first, one bit period each, driven from the byte selected by the byte index. Then PARITY or STOP.
- **STOP:** `tx`=1 for one bit period. At its end:
  - byte index <3: increment the index and go to START (no idle gap).
  - byte index =3 and FIFO non-empty: pop the next word and go to START.
  - otherwise: go to IDLE.
- **Baud counter:** counts 0..latched `clk_div`. The bit boundary is the cycle where the counter equals `clk_div`. The counter wraps to 0.
- **Divider changes:** changes on `clk_div` during a word are ignored. `clk_div`=0 gives one cycle per bit.
- **Reset:** aborts any frame in progress and clears the FIFO.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0, state IDLE.
- **Push-to-output latency:** push at cycle N into an empty, idle block:
  - N+1: `fifo_count`=1.
  - N+1: pop.
  - N+2: `tx`=0 (start bit begins).
  - Latency from push to start bit is 2 cycles.
- **Word duration:** 40·(`clk_div`+1) cycles without parity, 44·(`clk_div`+1) with parity.
- **Back-to-back words:** the next word's start bit immediately follows the previous word's last stop bit.
- **Reset mid-frame:** `aresetn`=0 sampled at edge K forces `tx`=1 and `busy`=0 from K.
- **Overflow pulse:** `overflow` asserts the cycle after the dropped `wr_en`.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** PARITY state inserted after data bit 7, driving the even-parity bit (XOR of the 8 data bits). Frame is 11 bits.
- **Undefined:** PARITY state and its logic are absent. Frame is 10 bits.

## Structure
- **Package `uart_32_bit_pkg`:**
  - state enum
  - `BYTES_PER_WORD`=4
  - `DATA_BITS`=8
  - `FRAME_BITS` (10 or 11, selected by the macro)
- **Sub-module `uart_32_bit_tx_fifo`:** synchronous FIFO with `full`, `count`, push/pop and same-cycle push+pop support. The framer contains the FSM, baud counter, bit counter and byte index.

## Test plan
- **Reset values:** hold `aresetn`=0 for 3 cycles → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0.
- **Single word:** `clk_div`=3, push 0xA5C30F81 → `tx` low at N+2, then 0x81, 0x0F, 0xC3, 0xA5 LSB first, 4 cycles per bit. `busy` falls after 160 cycles.
- **Back-to-back words:** `clk_div`=0, push 0x00000000 then 0xFFFFFFFF on consecutive cycles → 80 contiguous bit cycles, no idle high between the two words.
- **Overflow:** with `FIFO_DEPTH`=4 and `clk_div`=15, push 6 words on consecutive cycles. Word 1 is popped, words 2–5 fill the FIFO, word 6 → `overflow` pulse, `fifo_full`=1, `fifo_count`=4.
- **Reset mid-frame:** assert `aresetn`=0 during byte 2 → `tx`=1 and `fifo_count`=0 at the next edge, no further start bits.
- **Parity (`UART_TX_PARITY_EN`):** push 0x00000007 → byte 0 parity bit 1, bytes 1–3 parity bit 0. Word lasts 44·(`clk_div`+1) cycles.
